pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed first.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
REQ-002 The block SHALL have these stall-request inputs:
- stallreq_if  in  1  instruction fetch wait
- stallreq_id  in  1  load-use hazard
- stallreq_ex  in  1  multi-cycle EX operation
- stallreq_mem  in  1  data-bus wait
REQ-003 The block SHALL have these event inputs, all taken from the MEM stage:
- mem_excepttype  in  32  exception code
- mem_current_inst_addr  in  32  PC of the MEM instruction
- mem_branch_flag_real  in  1  mispredict redirect required
- mem_branch_tar_addr_real  in  32  redirect target
REQ-004 The block SHALL have these CSR inputs:
- csr_mtvec  in  32  trap vector
- csr_mepc  in  32  return address
REQ-005 The block SHALL have these outputs:
- stall  out  6  freeze vector; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
- flush  out  1  clear all pipeline registers
- new_pc  out  32  redirect address
- trap_commit  out  1  one-cycle pulse telling the CSR unit to save mepc/mcause
- trap_epc  out  32  PC to save into mepc
- stall_timeout  out  1  sticky watchdog flag

Function
REQ-006 The block SHALL have two states: RUN and FLUSH.
REQ-007 In RUN, events SHALL be handled in this priority order: exception, then branch redirect, then stall.
REQ-008 In RUN, when mem_excepttype != EXC_NONE:
- flush=1 and stall=6'b000000, combinationally in the same cycle.
- new_pc=csr_mepc for EXC_MRET; new_pc=csr_mtvec for every other code.
REQ-009 When the REQ-008 code is not EXC_MRET, trap_commit=1 and trap_epc=mem_current_inst_addr in that same cycle.
REQ-010 In RUN with no exception, when mem_branch_flag_real=1: flush=1, new_pc=mem_branch_tar_addr_real, trap_commit=0, stall=0.
REQ-011 Any flush SHALL move the state to FLUSH on the next edge.
REQ-012 In FLUSH:
- flush=0 and stall=0.
- All event and stall inputs are ignored.
- The state returns to RUN after exactly one cycle.
REQ-013 In RUN with no flush, stall SHALL be set by the deepest active request:
- mem: 6'b011111
- ex: 6'b001111
- id: 6'b000111
- if: 6'b000011
- none: 6'b000000
REQ-014 When flush=0, new_pc SHALL be 32'h0 and trap_commit=0.
REQ-015 An 8-bit counter SHALL increment on every cycle in which stall != 0.
- It saturates at 255.
- It clears on any cycle in which stall == 0.
REQ-016 stall_timeout SHALL set when the counter reaches 255 and stay set until reset.
REQ-017 An exception arriving while stall is nonzero SHALL win, i.e. flush=1 and stall=0 in the same cycle.

Reset
REQ-018 Reset SHALL force these values, taking effect at the first clk edge with rst=1:
- state=RUN, counter=0, stall_timeout=0.
- With rst held: stall=0, flush=0, new_pc=0, trap_commit=0, trap_epc=0.
REQ-019 Reset asserted while in FLUSH SHALL return the block to RUN with no pending flush.

Structure
REQ-020 A shared package/define file SHALL hold:
- EXC_NONE=0, EXC_ECALL=1, EXC_EBREAK=2, EXC_ILLEGAL=3, EXC_MRET=4, EXC_INT=5.
- The stall-vector constants of REQ-013.
- The state encoding.
REQ-021 The block SHALL contain one sub-module, stall_watchdog (the REQ-015/REQ-016 counter); all other logic stays flat.

Verification
REQ-022 A bench SHALL cover these directed scenarios:
- stallreq_ex=1 and stallreq_id=1 together -> stall=6'b001111; drop both -> stall=0 on the same cycle.
- mem_excepttype=EXC_ECALL, mem_current_inst_addr=32'h100, csr_mtvec=32'h80 -> flush=1, new_pc=32'h80, trap_commit=1, trap_epc=32'h100; next cycle flush=0, and all inputs are ignored.
- EXC_MRET with csr_mepc=32'h104 -> new_pc=32'h104, trap_commit=0.
- Branch flag=1 with target 32'h200 while stallreq_mem=1 -> flush=1, stall=0, new_pc=32'h200.
- stallreq_mem held for 300 cycles -> stall_timeout rises on cycle 255 and stays set after the request drops.
- rst=1 during FLUSH -> next cycle state=RUN; an exception applied in that cycle flushes immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: exception codes, stall
// vectors and the controller state encoding.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_NONE    = 32'd0;
  localparam logic [31:0] EXC_ECALL   = 32'd1;
  localparam logic [31:0] EXC_EBREAK  = 32'd2;
  localparam logic [31:0] EXC_ILLEGAL = 32'd3;
  localparam logic [31:0] EXC_MRET    = 32'd4;
  localparam logic [31:0] EXC_INT     = 32'd5;

  // Stall vector bits: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles (saturating at 255) and raises a sticky
// timeout flag once the count reaches 255.
module stall_watchdog (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  output logic timeout
);

  logic [7:0] cnt;
  logic [7:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (stall_active) begin
      cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end
  end

  // Flag is set on the same edge the counter reaches 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (cnt_next == 8'hFF) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: generates stall vector, flush and
// redirect PC, with a one-cycle FLUSH recovery state and a stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] mem_excepttype,
  input  logic [31:0] mem_current_inst_addr,
  input  logic        mem_branch_flag_real,
  input  logic [31:0] mem_branch_tar_addr_real,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        trap_commit,
  output logic [31:0] trap_epc,
  output logic        stall_timeout
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = RUN;
    if (state == RUN && flush) state_next = FLUSH;
  end

  // Outputs are held at zero while rst is asserted and throughout FLUSH.
  always_comb begin
    stall       = STALL_NONE;
    flush       = 1'b0;
    new_pc      = '0;
    trap_commit = 1'b0;
    trap_epc    = '0;
    if (!rst && state == RUN) begin
      if (mem_excepttype != EXC_NONE) begin
        flush = 1'b1;
        if (mem_excepttype == EXC_MRET) begin
          new_pc = csr_mepc;
        end else begin
          new_pc      = csr_mtvec;
          trap_commit = 1'b1;
          trap_epc    = mem_current_inst_addr;
        end
      end else if (mem_branch_flag_real) begin
        flush  = 1'b1;
        new_pc = mem_branch_tar_addr_real;
      end else if (stallreq_mem) begin
        stall = STALL_MEM;
      end else if (stallreq_ex) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end else if (stallreq_if) begin
        stall = STALL_IF;
      end
    end
  end

  stall_watchdog u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stall_active (|stall),
    .timeout      (stall_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the controller rules.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] mem_excepttype, mem_current_inst_addr;
  logic        mem_branch_flag_real;
  logic [31:0] mem_branch_tar_addr_real, csr_mtvec, csr_mepc;
  logic [5:0]  stall;
  logic        flush, trap_commit, stall_timeout;
  logic [31:0] new_pc, trap_epc;

  int total = 0;
  int bad   = 0;

  // Model state: whether the previous cycle flushed, run length of stalls, sticky flag
  bit m_in_flush = 1'b0;
  int m_run      = 0;
  bit m_timeout  = 1'b0;

  pipe_ctrl dut (
    .clk                      (clk),
    .rst                      (rst),
    .stallreq_if              (stallreq_if),
    .stallreq_id              (stallreq_id),
    .stallreq_ex              (stallreq_ex),
    .stallreq_mem             (stallreq_mem),
    .mem_excepttype           (mem_excepttype),
    .mem_current_inst_addr    (mem_current_inst_addr),
    .mem_branch_flag_real     (mem_branch_flag_real),
    .mem_branch_tar_addr_real (mem_branch_tar_addr_real),
    .csr_mtvec                (csr_mtvec),
    .csr_mepc                 (csr_mepc),
    .stall                    (stall),
    .flush                    (flush),
    .new_pc                   (new_pc),
    .trap_commit              (trap_commit),
    .trap_epc                 (trap_epc),
    .stall_timeout            (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    mem_excepttype = 0; mem_current_inst_addr = 0;
    mem_branch_flag_real = 0; mem_branch_tar_addr_real = 0;
    csr_mtvec = 0; csr_mepc = 0;
  endtask

  // Predict this cycle's outputs, compare at the falling edge, then advance the model.
  task automatic tick();
    logic [5:0]  e_stall = 6'd0;
    logic        e_flush = 0, e_tc = 0;
    logic [31:0] e_pc = 0, e_epc = 0;
    if (!rst && !m_in_flush) begin
      if (mem_excepttype != 0) begin
        e_flush = 1;
        e_tc    = (mem_excepttype != 4);
        e_pc    = e_tc ? csr_mtvec : csr_mepc;
        e_epc   = e_tc ? mem_current_inst_addr : 32'h0;
      end else if (mem_branch_flag_real) begin
        e_flush = 1;
        e_pc    = mem_branch_tar_addr_real;
      end else begin
        // Each stage request freezes itself and everything upstream of it.
        if      (stallreq_mem) e_stall = 6'h1F;
        else if (stallreq_ex)  e_stall = 6'h0F;
        else if (stallreq_id)  e_stall = 6'h07;
        else if (stallreq_if)  e_stall = 6'h03;
      end
    end
    @(negedge clk);
    chk("stall",       {26'd0, stall},       {26'd0, e_stall});
    chk("flush",       {31'd0, flush},       {31'd0, e_flush});
    chk("new_pc",      new_pc,               e_pc);
    chk("trap_commit", {31'd0, trap_commit}, {31'd0, e_tc});
    chk("trap_epc",    trap_epc,             e_epc);
    chk("timeout",     {31'd0, stall_timeout}, {31'd0, m_timeout});
    if (rst) begin
      m_in_flush = 0; m_run = 0; m_timeout = 0;
    end else begin
      m_in_flush = e_flush;
      m_run = (e_stall != 0) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
      if (m_run >= 255) m_timeout = 1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;
    tick(); tick();
    rst = 0;

    // EX+ID together -> EX vector; drop both -> zero in the same cycle
    stallreq_ex = 1; stallreq_id = 1; #1;
    chk("s1_stall", {26'd0, stall}, 32'h0F);
    tick();
    stallreq_ex = 0; stallreq_id = 0; #1;
    chk("s1_drop", {26'd0, stall}, 32'h0);
    tick();

    // ECALL trap, then FLUSH cycle ignores everything
    mem_excepttype = 1; mem_current_inst_addr = 32'h100; csr_mtvec = 32'h80; #1;
    chk("ecall_flush", {31'd0, flush}, 32'd1);
    chk("ecall_pc", new_pc, 32'h80);
    chk("ecall_tc", {31'd0, trap_commit}, 32'd1);
    chk("ecall_epc", trap_epc, 32'h100);
    tick();
    mem_excepttype = 3; mem_branch_flag_real = 1; stallreq_mem = 1; #1;
    chk("fl_flush", {31'd0, flush}, 32'd0);
    chk("fl_stall", {26'd0, stall}, 32'd0);
    tick();
    clr();

    // MRET returns to mepc without committing a trap
    mem_excepttype = 4; csr_mepc = 32'h104; #1;
    chk("mret_pc", new_pc, 32'h104);
    chk("mret_tc", {31'd0, trap_commit}, 32'd0);
    tick(); clr(); tick();

    // Branch redirect beats a MEM stall
    stallreq_mem = 1; mem_branch_flag_real = 1; mem_branch_tar_addr_real = 32'h200; #1;
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_stall", {26'd0, stall}, 32'd0);
    chk("br_pc", new_pc, 32'h200);
    tick(); clr(); tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst                      = ($urandom_range(0, 49) == 0);
      stallreq_if              = 1'($urandom_range(0, 1));
      stallreq_id              = 1'($urandom_range(0, 1));
      stallreq_ex              = 1'($urandom_range(0, 1));
      stallreq_mem             = 1'($urandom_range(0, 1));
      mem_excepttype           = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : 32'd0;
      mem_branch_flag_real     = ($urandom_range(0, 7) == 0);
      mem_current_inst_addr    = $urandom;
      mem_branch_tar_addr_real = $urandom;
      csr_mtvec                = $urandom;
      csr_mepc                 = $urandom;
      tick();
    end

    // Watchdog: MEM stall held 300 cycles
    rst = 1; clr(); tick(); rst = 0;
    stallreq_mem = 1;
    for (int i = 0; i < 300; i++) begin
      if (i == 254) chk("wd_254", {31'd0, stall_timeout}, 32'd0);
      if (i == 255) chk("wd_255", {31'd0, stall_timeout}, 32'd1);
      tick();
    end
    stallreq_mem = 0;
    tick(); tick(); tick();
    chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);

    // Reset during FLUSH returns to RUN; an exception then flushes at once
    rst = 1; tick(); rst = 0;
    mem_excepttype = 1; mem_current_inst_addr = 32'h40; csr_mtvec = 32'h300;
    tick();
    rst = 1; clr(); #1;
    chk("rstfl_flush", {31'd0, flush}, 32'd0);
    tick();
    rst = 0; mem_excepttype = 3; csr_mtvec = 32'h88; mem_current_inst_addr = 32'h50; #1;
    chk("rstfl_exc", {31'd0, flush}, 32'd1);
    chk("rstfl_pc", new_pc, 32'h88);
    tick(); clr(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
